// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, tag base and arbiter FSM encodings.
// UART_ARB_TAG_EN adds the TAG_ISSUE state used by tagged transfers.
package uart_pkg;

    localparam int                UART_W       = 8;
    localparam logic [UART_W-1:0] TAG_BASE_DEF = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG_ISSUE = 3'd4
`endif
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first request above i_last, wrapping.
// The grant pointer is held by the parent.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [2:0]   i_last,
    output logic [N-1:0] o_grant,
    output logic [2:0]   o_idx
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && i_req[j] &&
                    (j == (int'(i_last) + k) % N)) begin
                    w_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to prefix every byte with TAG_BASE | grant_id.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int BUSY_TIMEOUT = 16
`ifdef UART_ARB_TAG_EN
    ,
    parameter logic [UART_W-1:0] TAG_BASE = TAG_BASE_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [UART_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [UART_W-1:0]         snd_data,
    output logic                      snd_ready,
    input  logic                      snd_busy,
    output logic [2:0]                grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT);

    arb_state_e          r_state;
    arb_state_e          w_next;
    logic [2:0]          r_last;
    logic [2:0]          r_gid;
    logic [UART_W-1:0]   r_byte;
    logic [UART_W-1:0]   r_snd_data;
    logic                r_snd_ready;
    logic [TW-1:0]       r_timer;
    logic                r_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [2:0]          w_idx;
    logic [UART_W-1:0]   w_sel_byte;
    logic [UART_W-1:0]   w_tx_byte;
    logic                w_load;
    logic                w_strobe;
    logic                w_tmr_inc;
    logic                w_timeout;
    logic                w_clr_data;
`ifdef UART_ARB_TAG_EN
    logic                r_tag_phase;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_sel_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) w_sel_byte = req_data[UART_W*j +: UART_W];
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_strobe   = 1'b0;
        w_tx_byte  = r_byte;
        w_tmr_inc  = 1'b0;
        w_timeout  = 1'b0;
        w_clr_data = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_load = 1'b1;
`ifdef UART_ARB_TAG_EN
                    w_next = S_TAG_ISSUE;
`else
                    w_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (!snd_busy) begin
                    w_strobe = 1'b1;
                    w_next   = S_WAIT_RISE;
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG_ISSUE: begin
                if (!snd_busy) begin
                    w_strobe  = 1'b1;
                    w_tx_byte = TAG_BASE | {{(UART_W-3){1'b0}}, r_gid};
                    w_next    = S_WAIT_RISE;
                end
            end
`endif
            S_WAIT_RISE: begin
                if (snd_busy) begin
                    w_next = S_WAIT_FALL;
                end else if (r_timer == TW'(BUSY_TIMEOUT-1)) begin
                    // A lost handshake drops the whole grant, tag included
                    w_timeout  = 1'b1;
                    w_clr_data = 1'b1;
                    w_next     = S_IDLE;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!snd_busy) begin
                    w_clr_data = 1'b1;
`ifdef UART_ARB_TAG_EN
                    w_next = r_tag_phase ? S_ISSUE : S_IDLE;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= 3'(NUM_REQ-1);
            r_gid       <= '0;
            r_byte      <= '0;
            r_snd_data  <= '0;
            r_snd_ready <= 1'b0;
            r_timer     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_snd_ready <= w_strobe;
            if (w_load) begin
                r_byte <= w_sel_byte;
                r_gid  <= w_idx;
                r_last <= w_idx;
            end
            if (w_strobe) begin
                r_snd_data <= w_tx_byte;
                r_timer    <= '0;
            end else if (w_tmr_inc) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_clr_data) r_snd_data <= '0;
            if (w_timeout)  r_err      <= 1'b1;
        end
    end

`ifdef UART_ARB_TAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_phase <= 1'b0;
        end else if (w_strobe) begin
            r_tag_phase <= (r_state == S_TAG_ISSUE);
        end
    end
`endif

    assign req_ack     = (r_state == S_IDLE && !reset) ? w_grant : '0;
    assign snd_data    = r_snd_data;
    assign snd_ready   = r_snd_ready;
    assign grant_id    = r_gid;
    assign active      = (r_state != S_IDLE);
    assign timeout_err = r_err;

endmodule
